// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HDR,
    ARB_DATA
  } arb_state_e;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module uart_rr_arbiter #(
  parameter int NumReq = 4,
  parameter int IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    ptr,
  output logic [NumReq-1:0] onehot,
  output logic [IdW-1:0]    id,
  output logic              any
);

  always_comb begin
    int k;
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    k      = 0;
    // Walk from the farthest offset back to ptr so the nearest request wins.
    for (int i = NumReq - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NumReq) k = k - NumReq;
      if (req[k]) begin
        id  = IdW'(k);
        any = 1'b1;
      end
    end
    if (any) onehot[id] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants whole packets from NumReq byte streams round-robin onto the single UART TX
// write port, with an optional channel-ID header byte and a per-grant length cap.
//
// state    | meaning
// ARB_IDLE | no grant; pick next requester (no TX write this cycle)
// ARB_HDR  | send header byte HdrBase|grant id
// ARB_DATA | forward bytes of the granted lane until last or MaxBurst
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int                    NumReq     = 4,
  parameter int                    DataLength = 8,
  parameter bit                    HeaderEn   = 1'b1,
  parameter logic [DataLength-1:0] HdrBase    = DataLength'(HDR_BASE_DEFAULT),
  parameter int                    MaxBurst   = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NumReq-1:0]              i_req_valid,
  input  logic [NumReq*DataLength-1:0]   i_req_data,
  input  logic [NumReq-1:0]              i_req_last,
  output logic [NumReq-1:0]              o_req_ready,
  output logic [DataLength-1:0]          o_tx_data,
  output logic                           o_tx_req,
  input  logic                           i_tx_rdy,
  output logic                           o_grant_vld,
  output logic [$clog2(NumReq)-1:0]      o_grant_id,
  output logic                           o_burst_cut
);

  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);

  arb_state_e          state_q, state_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [IdW-1:0]      gid_q, gid_d;
  logic [NumReq-1:0]   goh_q, goh_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                gvld_q, cut_q, cut_d;

  logic [NumReq-1:0]     pick_onehot;
  logic [IdW-1:0]        pick_id;
  logic                  pick_any;
  logic [DataLength-1:0] hdr_byte;
  logic                  lane_valid, lane_last;
  logic [DataLength-1:0] lane_data [NumReq];

  for (genvar k = 0; k < NumReq; k++) begin : g_lane
    assign lane_data[k] = i_req_data[k*DataLength +: DataLength];
  end

  uart_rr_arbiter #(.NumReq(NumReq), .IdW(IdW)) u_rr (
    .req    (i_req_valid),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .id     (pick_id),
    .any    (pick_any)
  );

  assign lane_valid = |(i_req_valid & goh_q);
  assign lane_last  = |(i_req_last & goh_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    goh_d       = goh_q;
    cnt_d       = cnt_q;
    cut_d       = 1'b0;
    o_tx_req    = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;
    hdr_byte    = HdrBase;
    hdr_byte[IdW-1:0] = gid_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gid_d   = pick_id;
          goh_d   = pick_onehot;
          cnt_d   = '0;
          state_d = HeaderEn ? ARB_HDR : ARB_DATA;
        end
      end
      ARB_HDR: begin
        o_tx_data = hdr_byte;
        o_tx_req  = i_tx_rdy;
        if (i_tx_rdy) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        o_tx_data   = lane_data[gid_q];
        o_req_ready = goh_q & {NumReq{i_tx_rdy}};
        o_tx_req    = i_tx_rdy & lane_valid;
        if (o_tx_req) begin
          cnt_d = cnt_q + CntW'(1);
          // A cap hit on the final byte counts as a normal packet end.
          if (lane_last || cnt_q == CntW'(MaxBurst - 1)) begin
            state_d = ARB_IDLE;
            ptr_d   = (gid_q == IdW'(NumReq - 1)) ? '0 : gid_q + IdW'(1);
            cut_d   = ~lane_last;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      goh_q   <= '0;
      cnt_q   <= '0;
      gvld_q  <= 1'b0;
      cut_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      goh_q   <= goh_d;
      cnt_q   <= cnt_d;
      gvld_q  <= (state_d != ARB_IDLE);
      cut_q   <= cut_d;
    end
  end

  assign o_grant_vld = gvld_q;
  assign o_grant_id  = gid_q;
  assign o_burst_cut = cut_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle vector table, directed corner
// sequences and randomized packet streams against a packet-level queue model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int MB = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_req_valid, i_req_last, o_req_ready;
  logic [31:0] i_req_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_req, i_tx_rdy, o_grant_vld, o_burst_cut;
  logic [1:0]  o_grant_id;

  logic [3:0]  nh_valid, nh_last, nh_ready;
  logic [31:0] nh_data;
  logic [7:0]  nh_tx_data;
  logic        nh_tx_req, nh_grant_vld, nh_burst_cut;
  logic [1:0]  nh_grant_id;

  always #5 i_clk = ~i_clk;

  uart_tx_arbiter #(.NumReq(NR), .DataLength(8), .HeaderEn(1'b1), .HdrBase(8'hA0), .MaxBurst(MB)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .i_req_last(i_req_last), .o_req_ready(o_req_ready), .o_tx_data(o_tx_data), .o_tx_req(o_tx_req),
    .i_tx_rdy(i_tx_rdy), .o_grant_vld(o_grant_vld), .o_grant_id(o_grant_id), .o_burst_cut(o_burst_cut)
  );

  uart_tx_arbiter #(.NumReq(NR), .DataLength(8), .HeaderEn(1'b0), .HdrBase(8'hA0), .MaxBurst(MB)) u_dut_nh (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(nh_valid), .i_req_data(nh_data),
    .i_req_last(nh_last), .o_req_ready(nh_ready), .o_tx_data(nh_tx_data), .o_tx_req(nh_tx_req),
    .i_tx_rdy(i_tx_rdy), .o_grant_vld(nh_grant_vld), .o_grant_id(nh_grant_id), .o_burst_cut(nh_burst_cut)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        rdy;
    logic [16:0] exp;   // {tx_req, tx_data, req_ready, grant_vld, grant_id, burst_cut}
  } vec_t;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [7:0] d0, logic [7:0] d1, logic rdy,
                              logic req, logic [7:0] dat, logic [3:0] rv, logic gv, logic [1:0] gid, logic cut);
    vec_t t;
    t.v = v; t.l = l; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
    t.exp = {req, dat, rv, gv, gid, cut};
    return t;
  endfunction

  // Per-lane byte queues: bit 8 = last flag.
  logic [8:0] lbuf [NR][64];
  int         hd [NR];
  int         tl [NR];
  int         mdl_ptr = 0;
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int         cut_seen;

  task automatic clear_lanes();
    for (int k = 0; k < NR; k++) begin hd[k] = 0; tl[k] = 0; end
  endtask

  task automatic push_pkt(input int lane, input int len, input logic [7:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      lbuf[lane][tl[lane]] = {(i == len - 1), (rnd ? 8'($urandom) : base + 8'(i))};
      tl[lane]++;
    end
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int k = 0; k < NR; k++) if (hd[k] < tl[k]) p = 1;
    return p;
  endfunction

  // Packet-level model: every lane with queued bytes is eager, so the output is the
  // round-robin interleave of queued packets, each grant capped at MB bytes.
  task automatic build_expected(input bit hdr_en, output int cuts);
    int h [NR];
    int g, n;
    bit ended;
    exp_q.delete();
    cuts = 0;
    for (int k = 0; k < NR; k++) h[k] = hd[k];
    forever begin
      g = -1;
      for (int i = 0; i < NR; i++) begin
        automatic int k = (mdl_ptr + i) % NR;
        if (g < 0 && h[k] < tl[k]) g = k;
      end
      if (g < 0) break;
      if (hdr_en) exp_q.push_back((8'hA0 & 8'hFC) | 8'(g));
      n = 0;
      ended = 0;
      while (!ended && n < MB) begin
        exp_q.push_back(lbuf[g][h[g]][7:0]);
        ended = lbuf[g][h[g]][8];
        h[g]++;
        n++;
      end
      if (!ended) cuts++;
      mdl_ptr = (g + 1) % NR;
    end
  endtask

  task automatic drive_lanes();
    for (int k = 0; k < NR; k++) begin
      if (hd[k] < tl[k]) begin
        i_req_valid[k]       = 1'b1;
        i_req_data[k*8 +: 8] = lbuf[k][hd[k]][7:0];
        i_req_last[k]        = lbuf[k][hd[k]][8];
      end else begin
        i_req_valid[k]       = 1'b0;
        i_req_data[k*8 +: 8] = 8'h00;
        i_req_last[k]        = 1'b0;
      end
    end
  endtask

  task automatic sample();
    if (o_burst_cut) cut_seen++;
    if (o_tx_req) obs_q.push_back(o_tx_data);
    for (int k = 0; k < NR; k++) if (i_req_valid[k] && o_req_ready[k]) hd[k]++;
  endtask

  task automatic run_stream(input string name, input bit rnd_rdy);
    int exp_cuts, cyc, m;
    build_expected(1'b1, exp_cuts);
    obs_q.delete();
    cut_seen = 0;
    cyc = 0;
    while (pending() && cyc < 4000) begin
      @(negedge i_clk);
      drive_lanes();
      i_tx_rdy = rnd_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
      #1;
      sample();
      cyc++;
    end
    if (cyc >= 4000) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d cycles expected < 4000", name, cyc);
    end
    repeat (3) begin
      @(negedge i_clk);
      drive_lanes();
      i_tx_rdy = 1'b1;
      #1;
      sample();
    end
    check({name, "_len"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_b%0d", name, i), obs_q[i], exp_q[i]);
    check({name, "_cuts"}, cut_seen, exp_cuts);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req_valid = '0; i_req_last = '0; i_req_data = '0; i_tx_rdy = 1'b0;
    nh_valid = '0; nh_last = '0; nh_data = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    mdl_ptr = 0;
  endtask

  vec_t       tbl [12];
  logic [7:0] want [8];
  logic [7:0] nh_bytes [2];
  logic [7:0] nh_obs [$];
  int         ni, nh_cuts;

  initial begin
    tbl[0]  = mk(4'b0010, 4'b0000, 8'h00, 8'h11, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
    tbl[1]  = mk(4'b0010, 4'b0000, 8'h00, 8'h11, 1, 1, 8'hA1, 4'b0000, 1, 2'd1, 0);
    tbl[2]  = mk(4'b0010, 4'b0000, 8'h00, 8'h11, 0, 0, 8'h11, 4'b0000, 1, 2'd1, 0);
    tbl[3]  = mk(4'b0010, 4'b0000, 8'h00, 8'h11, 1, 1, 8'h11, 4'b0010, 1, 2'd1, 0);
    tbl[4]  = mk(4'b0010, 4'b0000, 8'h00, 8'h22, 0, 0, 8'h22, 4'b0000, 1, 2'd1, 0);
    tbl[5]  = mk(4'b0010, 4'b0000, 8'h00, 8'h22, 1, 1, 8'h22, 4'b0010, 1, 2'd1, 0);
    tbl[6]  = mk(4'b0000, 4'b0010, 8'h00, 8'h33, 1, 0, 8'h33, 4'b0010, 1, 2'd1, 0);
    tbl[7]  = mk(4'b0011, 4'b0011, 8'h55, 8'h33, 1, 1, 8'h33, 4'b0010, 1, 2'd1, 0);
    tbl[8]  = mk(4'b0001, 4'b0001, 8'h55, 8'h00, 1, 0, 8'h00, 4'b0000, 0, 2'd1, 0);
    tbl[9]  = mk(4'b0001, 4'b0001, 8'h55, 8'h00, 1, 1, 8'hA0, 4'b0000, 1, 2'd0, 0);
    tbl[10] = mk(4'b0001, 4'b0001, 8'h55, 8'h00, 1, 1, 8'h55, 4'b0001, 1, 2'd0, 0);
    tbl[11] = mk(4'b0000, 4'b0000, 8'h00, 8'h00, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
    want = '{8'hA0, 8'h10, 8'hA1, 8'h20, 8'hA2, 8'h30, 8'hA0, 8'h11};
    nh_bytes = '{8'h77, 8'h78};

    // Reset state, with requests asserted while in reset.
    i_rst_n = 1'b0;
    i_req_valid = 4'b1111; i_req_last = '0; i_req_data = 32'h4433_2211; i_tx_rdy = 1'b1;
    nh_valid = 4'b1111; nh_last = '0; nh_data = '0;
    @(negedge i_clk); #1;
    check("reset_outputs", {15'b0, o_tx_req, o_tx_data, o_req_ready, o_grant_vld, o_grant_id, o_burst_cut}, 32'h0);
    check("reset_outputs_nh", {nh_tx_req, nh_ready, nh_grant_vld}, 6'b0);
    do_reset();

    // Cycle vectors: packet 11,22,33 on lane 1 with rdy stalls and a valid gap, then lane 0.
    for (int r = 0; r < 12; r++) begin
      @(negedge i_clk);
      i_req_valid = tbl[r].v;
      i_req_last  = tbl[r].l;
      i_req_data  = {16'h0, tbl[r].d1, tbl[r].d0};
      i_tx_rdy    = tbl[r].rdy;
      #1;
      check($sformatf("vec%0d", r),
            {15'b0, o_tx_req, o_tx_data, o_req_ready, o_grant_vld, o_grant_id, o_burst_cut},
            {15'b0, tbl[r].exp});
    end

    // Reset in the middle of a lane-2 packet; pointer must restart at 0.
    do_reset();
    clear_lanes();
    push_pkt(0, 1, 8'h01, 0);
    run_stream("t6_pre", 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      i_req_valid = 4'b0100; i_req_last = '0; i_req_data = 32'h0040_0000; i_tx_rdy = 1'b1;
    end
    @(negedge i_clk); #2;
    check("t6_gvld_before", o_grant_vld, 1);
    check("t6_txreq_before", o_tx_req, 1);
    i_rst_n = 1'b0;
    #1;
    check("t6_txreq_in_reset", o_tx_req, 0);
    check("t6_gvld_in_reset", o_grant_vld, 0);
    check("t6_ready_in_reset", o_req_ready, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_req_valid = 4'b0101; i_req_last = 4'b0001; i_req_data = 32'h0040_0002;
    #1;
    check("t6_idle_after", {o_grant_vld, o_tx_req}, 2'b00);
    @(negedge i_clk); #1;
    check("t6_hdr_byte", o_tx_data, 8'hA0);
    check("t6_hdr_id", o_grant_id, 2'd0);
    check("t6_hdr_req", o_tx_req, 1);

    // Round-robin wrap: header order A0, A1, A2, A0.
    do_reset();
    clear_lanes();
    push_pkt(0, 1, 8'h10, 0); push_pkt(0, 1, 8'h11, 0);
    push_pkt(1, 1, 8'h20, 0);
    push_pkt(2, 1, 8'h30, 0);
    run_stream("rr", 0);
    for (int i = 0; i < 8; i++) check($sformatf("rr_gold%0d", i), obs_q[i], want[i]);

    // 20 bytes on lane 3: cut after 16, re-granted for the remaining 4.
    clear_lanes();
    push_pkt(3, 20, 8'h40, 0);
    run_stream("burst", 0);
    check("burst_total", obs_q.size(), 22);
    check("burst_cut_pulses", cut_seen, 1);
    check("burst_regrant_hdr", obs_q[17], 8'hA3);

    // Last on the 16th byte: normal end, no cut.
    clear_lanes();
    push_pkt(2, 16, 8'h60, 0);
    run_stream("edge16", 0);
    check("edge16_cut_pulses", cut_seen, 0);

    // Randomized packets with random rdy stalls.
    for (int round = 0; round < 4; round++) begin
      clear_lanes();
      for (int k = 0; k < NR; k++) begin
        automatic int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) push_pkt(k, $urandom_range(1, 20), 8'h00, 1);
      end
      run_stream($sformatf("rnd%0d", round), 1);
    end

    // Header-less build: only data bytes reach the UART.
    i_req_valid = '0;
    ni = 0;
    nh_cuts = 0;
    nh_obs.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      nh_valid = (ni < 2) ? 4'b0010 : 4'b0000;
      nh_data  = (ni < 2) ? {16'h0, nh_bytes[ni[0]], 8'h00} : 32'h0;
      nh_last  = (ni == 1) ? 4'b0010 : 4'b0000;
      i_tx_rdy = 1'b1;
      #1;
      if (nh_burst_cut) nh_cuts++;
      if (nh_tx_req) nh_obs.push_back(nh_tx_data);
      if (nh_valid[1] && nh_ready[1]) ni++;
    end
    check("nh_len", nh_obs.size(), 2);
    check("nh_b0", nh_obs[0], 8'h77);
    check("nh_b1", nh_obs[1], 8'h78);
    check("nh_gvld_end", nh_grant_vld, 0);
    check("nh_gid_end", nh_grant_id, 2'd1);
    check("nh_cuts", nh_cuts, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
